reg_wb_queue: RTL and testbench

// - Write-side producer for the 32x32 register file: buffers writeback requests (dest reg, data) from the
//   MEM/WB stage and multi-cycle units, drains one per cycle onto the register file write port.
// - Provides a lookup port so decode can detect/forward values still queued and not yet committed.

---
 rtl/reg_wb_queue_if.sv | 36 +++
 rtl/reg_wb_queue.sv | 137 +++++++++++++
 tb/tb_reg_wb_queue.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_queue_if.sv
// Writeback-queue bus: enqueue handshake, regfile write port, decode lookup ports and occupancy.
interface reg_wb_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_reg;
    logic [DW-1:0] enq_data;
    logic          wb_en;
    logic          regwrite;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic [AW-1:0] q1_reg;
    logic [AW-1:0] q2_reg;
    logic          q1_hit;
    logic [DW-1:0] q1_data;
    logic          q2_hit;
    logic [DW-1:0] q2_data;
    logic [CW-1:0] count;

    modport master (
        output enq_valid, enq_reg, enq_data, wb_en, q1_reg, q2_reg,
        input  enq_ready, regwrite, writereg, writedata,
               q1_hit, q1_data, q2_hit, q2_data, count
    );

    modport slave (
        input  enq_valid, enq_reg, enq_data, wb_en, q1_reg, q2_reg,
        output enq_ready, regwrite, writereg, writedata,
               q1_hit, q1_data, q2_hit, q2_data, count
    );
endinterface

// File: rtl/reg_wb_queue.sv
// Register-file writeback queue: FIFO of (reg, data) drained one per cycle, with pending-write lookup.
// Define WBQ_FORWARD_EN to drive q*_data with the newest pending value; otherwise q*_data is tied to 0.
module reg_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    reg_wb_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] writereg_q, writereg_d;
    logic [DW-1:0] writedata_q, writedata_d;

    logic enq_ready_c;
    logic push_c;
    logic pop_c;

    assign enq_ready_c   = (count_q < CW'(DEPTH));
    assign bus.enq_ready = enq_ready_c;
    assign bus.count     = count_q;
    assign bus.regwrite  = regwrite_q;
    assign bus.writereg  = writereg_q;
    assign bus.writedata = writedata_q;

    // Pop decision uses only the stored count, so a same-cycle enqueue is never popped.
    always_comb begin
        push_c      = bus.enq_valid && enq_ready_c && (bus.enq_reg != '0);
        pop_c       = (count_q != '0) && bus.wb_en;
        head_d      = head_q;
        tail_d      = tail_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        if (pop_c) begin
            head_d      = head_q + PW'(1);
            regwrite_d  = 1'b1;
            writereg_d  = reg_q[head_q];
            writedata_d = data_q[head_q];
        end
        if (push_c) begin
            tail_d = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            reg_q[tail_q]  <= bus.enq_reg;
            data_q[tail_q] <= bus.enq_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Scan oldest to newest so later matches overwrite; output reg is oldest of all.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        if (a != '0) begin
            if (regwrite_q && (writereg_q == a)) begin
                r = {1'b1, writedata_q};
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (reg_q[idx] == a)) begin
                    r = {1'b1, data_q[idx]};
                end
            end
        end
        return r;
    endfunction

    logic [DW:0] lk1_c, lk2_c;

    assign lk1_c       = lookup(bus.q1_reg);
    assign lk2_c       = lookup(bus.q2_reg);
    assign bus.q1_hit  = lk1_c[DW];
    assign bus.q1_data = lk1_c[DW-1:0];
    assign bus.q2_hit  = lk2_c[DW];
    assign bus.q2_data = lk2_c[DW-1:0];
`else
    // Hazard detect only: any pending write to the register.
    function automatic logic pending(input logic [AW-1:0] a);
        logic          h;
        logic [PW-1:0] idx;
        h = 1'b0;
        if (a != '0) begin
            if (regwrite_q && (writereg_q == a)) begin
                h = 1'b1;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (reg_q[idx] == a)) begin
                    h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    assign bus.q1_hit  = pending(bus.q1_reg);
    assign bus.q2_hit  = pending(bus.q2_reg);
    assign bus.q1_data = '0;
    assign bus.q2_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: queue-based reference model compared every cycle, plus literal checks.
module tb_reg_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
    reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the last popped write.
    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    bit            m_rw    = 1'b0;
    logic [AW-1:0] m_wreg  = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_take;
    ent_t          m_head;
    logic [DW:0]   lk;

    function automatic logic [DW:0] m_look(input logic [AW-1:0] a);
        if (a == '0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == a) return {1'b1, mq[i].d};
        end
        if (m_rw && (m_wreg == a)) return {1'b1, m_wdata};
        return '0;
    endfunction

    always @(posedge rst) begin
        mq.delete();
        m_rw    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rw    = 1'b0;
            m_wreg  = '0;
            m_wdata = '0;
        end else begin
            m_take = bus.enq_valid && (mq.size() < int'(DEPTH)) && (bus.enq_reg != '0);
            if (bus.wb_en && (mq.size() > 0)) begin
                m_head  = mq.pop_front();
                m_rw    = 1'b1;
                m_wreg  = m_head.r;
                m_wdata = m_head.d;
            end else begin
                m_rw = 1'b0;
            end
            if (m_take) mq.push_back({bus.enq_reg, bus.enq_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_count",     64'(bus.count),     64'(mq.size()));
            chk("m_enq_ready", 64'(bus.enq_ready), 64'(mq.size() < int'(DEPTH)));
            chk("m_regwrite",  64'(bus.regwrite),  64'(m_rw));
            chk("m_writereg",  64'(bus.writereg),  64'(m_wreg));
            chk("m_writedata", 64'(bus.writedata), 64'(m_wdata));
            lk = m_look(bus.q1_reg);
            chk("m_q1_hit",  64'(bus.q1_hit),  64'(lk[DW]));
            chk("m_q1_data", 64'(bus.q1_data), FWD ? 64'(lk[DW-1:0]) : 64'(0));
            lk = m_look(bus.q2_reg);
            chk("m_q2_hit",  64'(bus.q2_hit),  64'(lk[DW]));
            chk("m_q2_data", 64'(bus.q2_data), FWD ? 64'(lk[DW-1:0]) : 64'(0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input bit v, input int r, input int unsigned d);
        bus.enq_valid = v;
        bus.enq_reg   = AW'(r);
        bus.enq_data  = DW'(d);
    endtask

    initial begin
        set_enq(1'b0, 0, 0);
        bus.wb_en  = 1'b0;
        bus.q1_reg = '0;
        bus.q2_reg = '0;
        cyc();
        chk("rst_regwrite",  64'(bus.regwrite),  64'(0));
        chk("rst_count",     64'(bus.count),     64'(0));
        chk("rst_writereg",  64'(bus.writereg),  64'(0));
        chk("rst_writedata", 64'(bus.writedata), 64'(0));
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'(1));
        cyc();
        rst = 1'b0;

        // Single write latency
        bus.wb_en = 1'b1;
        set_enq(1'b1, 5, 32'hDEADBEEF);
        cyc();
        set_enq(1'b0, 0, 0);
        chk("single_count_e0", 64'(bus.count),    64'(1));
        chk("single_rw_e0",    64'(bus.regwrite), 64'(0));
        cyc();
        chk("single_rw_e1",   64'(bus.regwrite),  64'(1));
        chk("single_reg_e1",  64'(bus.writereg),  64'(5));
        chk("single_data_e1", 64'(bus.writedata), 64'(32'hDEADBEEF));
        cyc();
        chk("single_rw_e2", 64'(bus.regwrite), 64'(0));

        // Fill with drain held, then backpressure and ordered release
        bus.wb_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_enq(1'b1, i, 32'h100 + i);
            cyc();
        end
        chk("full_count", 64'(bus.count),     64'(4));
        chk("full_ready", 64'(bus.enq_ready), 64'(0));
        set_enq(1'b1, 9, 32'h99);
        cyc();
        cyc();
        chk("held_count", 64'(bus.count),    64'(4));
        chk("held_rw",    64'(bus.regwrite), 64'(0));
        bus.wb_en = 1'b1;
        cyc();
        chk("drain1_reg",   64'(bus.writereg),  64'(1));
        chk("drain1_data",  64'(bus.writedata), 64'(32'h101));
        chk("drain1_count", 64'(bus.count),     64'(3));
        cyc();
        set_enq(1'b0, 0, 0);
        chk("drain2_reg",   64'(bus.writereg), 64'(2));
        chk("drain2_count", 64'(bus.count),    64'(3));
        cyc();
        chk("drain3_reg", 64'(bus.writereg), 64'(3));
        cyc();
        chk("drain4_reg", 64'(bus.writereg), 64'(4));
        cyc();
        chk("drain5_reg",  64'(bus.writereg),  64'(9));
        chk("drain5_data", 64'(bus.writedata), 64'(32'h99));
        cyc();
        chk("drain_done_rw", 64'(bus.regwrite), 64'(0));

        // Register 0 writes are accepted but dropped
        set_enq(1'b1, 0, 32'h1234);
        cyc();
        set_enq(1'b0, 0, 0);
        chk("r0_count", 64'(bus.count),     64'(0));
        chk("r0_ready", 64'(bus.enq_ready), 64'(1));
        cyc();
        chk("r0_rw_a", 64'(bus.regwrite), 64'(0));
        cyc();
        chk("r0_rw_b", 64'(bus.regwrite), 64'(0));

        // Forwarding: newest of two writes to r7, output register still visible
        bus.wb_en  = 1'b0;
        bus.q1_reg = AW'(7);
        bus.q2_reg = '0;
        set_enq(1'b1, 7, 32'h11);
        cyc();
        chk("fwd_same_cycle_hidden", 64'(bus.q1_data), FWD ? 64'(32'h11) : 64'(0));
        set_enq(1'b1, 7, 32'h22);
        cyc();
        set_enq(1'b0, 0, 0);
        chk("fwd_q1_hit",  64'(bus.q1_hit),  64'(1));
        chk("fwd_q1_data", 64'(bus.q1_data), FWD ? 64'(32'h22) : 64'(0));
        chk("fwd_q2_hit0", 64'(bus.q2_hit),  64'(0));
        bus.wb_en = 1'b1;
        cyc();
        chk("fwd_mix_hit",  64'(bus.q1_hit),  64'(1));
        chk("fwd_mix_data", 64'(bus.q1_data), FWD ? 64'(32'h22) : 64'(0));
        cyc();
        chk("fwd_out_hit",  64'(bus.q1_hit),  64'(1));
        chk("fwd_out_data", 64'(bus.q1_data), FWD ? 64'(32'h22) : 64'(0));
        bus.q2_reg = AW'(7);
        #1;
        chk("fwd_q2_hit",  64'(bus.q2_hit),  64'(1));
        chk("fwd_q2_data", 64'(bus.q2_data), FWD ? 64'(32'h22) : 64'(0));
        cyc();
        chk("fwd_commit_q1", 64'(bus.q1_hit), 64'(0));
        chk("fwd_commit_q2", 64'(bus.q2_hit), 64'(0));

        // Wrap with simultaneous enqueue and pop every cycle
        bus.q1_reg = AW'(13);
        bus.q2_reg = AW'(20);
        bus.wb_en  = 1'b0;
        set_enq(1'b1, 10, 32'h200);
        cyc();
        set_enq(1'b1, 11, 32'h201);
        cyc();
        bus.wb_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_enq(1'b1, 12 + i, 32'h300 + i);
            cyc();
            chk("wrap_count", 64'(bus.count),    64'(2));
            chk("wrap_reg",   64'(bus.writereg), 64'(10 + i));
        end
        set_enq(1'b0, 0, 0);
        cyc();
        cyc();
        cyc();
        chk("wrap_empty", 64'(bus.count), 64'(0));
        bus.q1_reg = '0;
        bus.q2_reg = '0;

        // Asynchronous reset in the middle of a drain
        bus.wb_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_enq(1'b1, i, 32'hA0 + i);
            cyc();
        end
        set_enq(1'b0, 0, 0);
        bus.wb_en = 1'b1;
        cyc();
        chk("pre_rst_rw",    64'(bus.regwrite), 64'(1));
        chk("pre_rst_count", 64'(bus.count),    64'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rw",       64'(bus.regwrite), 64'(0));
        chk("midrst_count",    64'(bus.count),    64'(0));
        chk("midrst_writereg", 64'(bus.writereg), 64'(0));
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_rw_a", 64'(bus.regwrite), 64'(0));
        cyc();
        chk("post_rst_rw_b",  64'(bus.regwrite), 64'(0));
        chk("post_rst_count", 64'(bus.count),    64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
